// File: rtl/playseq_pkg.sv
// Shared definitions for the PlaySeq input-conditioning slice: debouncer
// state codes (also shown on hexa7seg) and default parameter values.
package playseq_pkg;

  localparam int N_BOTOES_PADRAO = 4;
  localparam int DEBOUNCE_PADRAO = 50000;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    FILTRA  = 4'd1,
    ESTAVEL = 4'd2,
    SEGURA  = 4'd3,
    SOLTA   = 4'd4
  } estado_t;

endpackage

// File: rtl/playseq_filtro_bit.sv
// One-bit conditioner: two-flop synchronizer, press/release debouncer and a
// single-cycle pulse on each debounced rising edge.
module playseq_filtro_bit
  import playseq_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic pulso
);

  localparam int            CW      = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);

  logic          sync_p0;
  logic          sync_p1;
  estado_t       estado;
  estado_t       estado_prox;
  logic [CW-1:0] cnt;
  logic          conta;

  // Synchronizer stage: bring the asynchronous key level into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= entrada;
      sync_p1 <= sync_p0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  // Next-state logic: filter the press, emit once, then filter the release.
  always_comb begin
    estado_prox = estado;
    conta       = 1'b0;
    case (estado)
      OCIOSO:  if (sync_p1) estado_prox = FILTRA;
      FILTRA: begin
        if (!sync_p1) begin
          estado_prox = OCIOSO;
        end else begin
          conta = 1'b1;
          if (cnt == CNT_FIM) estado_prox = ESTAVEL;
        end
      end
      ESTAVEL: estado_prox = SEGURA;
      SEGURA:  if (!sync_p1) estado_prox = SOLTA;
      SOLTA: begin
        if (sync_p1) begin
          estado_prox = SEGURA;
        end else begin
          conta = 1'b1;
          if (cnt == CNT_FIM) estado_prox = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // Stability counter: restarts on every state change and saturates at the end value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (estado_prox != estado) begin
      cnt <= '0;
    end else if (conta && (cnt != CNT_FIM)) begin
      cnt <= cnt + CNT_UM;
    end
  end

  // Output stage: registered pulse for the single ESTAVEL cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pulso <= 1'b0;
    else        pulso <= (estado == ESTAVEL);
  end

endmodule

// File: rtl/playseq_condicionador_entradas.sv
// Input conditioning for the PlaySeq top level: synchronizes and debounces
// the play buttons and the jogar key, registers a one-hot play code and
// flags multi-button presses.
module playseq_condicionador_entradas
  import playseq_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_in,
  input  logic                jogar_in,
  output logic [N_BOTOES-1:0] botoes,
  output logic                tem_jogada,
  output logic                jogar,
  output logic                multiplo,
  output logic [3:0]          db_estado
);

  localparam int                  CW      = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0]       CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0]       CNT_UM  = CW'(1);
  localparam logic [N_BOTOES-1:0] VEC_UM  = N_BOTOES'(1);

  logic [N_BOTOES-1:0] sync_p0;
  logic [N_BOTOES-1:0] sync_p1;
  logic [N_BOTOES-1:0] cand;
  estado_t             estado;
  estado_t             estado_prox;
  logic [CW-1:0]       cnt;
  logic                conta;
  logic                cand_um_quente;

  // A vector is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
  assign cand_um_quente = (cand != '0) && ((cand & (cand - VEC_UM)) == '0);
  assign db_estado      = estado;

  // Synchronizer stage: two flops per button bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= botoes_in;
      sync_p1 <= sync_p0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  // Next-state logic: the whole vector must stay unchanged to be accepted.
  always_comb begin
    estado_prox = estado;
    conta       = 1'b0;
    case (estado)
      OCIOSO:  if (sync_p1 != '0) estado_prox = FILTRA;
      FILTRA: begin
        if (sync_p1 != cand) begin
          estado_prox = OCIOSO;
        end else begin
          conta = 1'b1;
          if (cnt == CNT_FIM) estado_prox = ESTAVEL;
        end
      end
      ESTAVEL: estado_prox = SEGURA;
      SEGURA:  if (sync_p1 == '0) estado_prox = SOLTA;
      SOLTA: begin
        if (sync_p1 != '0) begin
          estado_prox = SEGURA;
        end else begin
          conta = 1'b1;
          if (cnt == CNT_FIM) estado_prox = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // Candidate capture and stability counter (restarts on each state change, never wraps).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand <= '0;
      cnt  <= '0;
    end else begin
      if ((estado == OCIOSO) && (sync_p1 != '0)) cand <= sync_p1;
      if (estado_prox != estado) begin
        cnt <= '0;
      end else if (conta && (cnt != CNT_FIM)) begin
        cnt <= cnt + CNT_UM;
      end
    end
  end

  // Output stage: accept a one-hot play or flag a multi-button press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes     <= '0;
      tem_jogada <= 1'b0;
      multiplo   <= 1'b0;
    end else if (estado == ESTAVEL) begin
      if (cand_um_quente) begin
        botoes     <= cand;
        tem_jogada <= 1'b1;
        multiplo   <= 1'b0;
      end else begin
        tem_jogada <= 1'b0;
        multiplo   <= 1'b1;
      end
    end else begin
      tem_jogada <= 1'b0;
      multiplo   <= 1'b0;
    end
  end

  playseq_filtro_bit #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_filtro_jogar (
    .clock  (clock),
    .reset  (reset),
    .entrada(jogar_in),
    .pulso  (jogar)
  );

endmodule

// File: tb/tb_playseq_condicionador_entradas.sv
// Bench for playseq_condicionador_entradas with DEBOUNCE_CICLOS=4: directed
// scenarios plus randomized press sequences against a timestamp-based model.
module tb_playseq_condicionador_entradas;

  localparam int D = 4;

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic [3:0] botoes_in = 4'b0;
  logic       jogar_in  = 1'b0;
  logic [3:0] botoes;
  logic       tem_jogada;
  logic       jogar;
  logic       multiplo;
  logic [3:0] db_estado;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_tem  = 0;
  int cnt_jog  = 0;
  int cnt_mult = 0;

  playseq_condicionador_entradas #(
    .N_BOTOES       (4),
    .DEBOUNCE_CICLOS(D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .botoes_in (botoes_in),
    .jogar_in  (jogar_in),
    .botoes    (botoes),
    .tem_jogada(tem_jogada),
    .jogar     (jogar),
    .multiplo  (multiplo),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // Reference model: a channel remembers when its candidate was first seen
  // (or when the release began) and decides by elapsed sample count.
  // ph: 0 idle, 1 filtering, 2 accepted, 3 held, 4 releasing.
  typedef struct {
    int         ph;
    logic [3:0] cand;
    int         t0;
    logic       pulso;
    logic       mult;
  } canal_t;

  canal_t     mb;
  canal_t     mj;
  logic [3:0] rb1, rb2;
  logic       rj1, rj2;
  logic [3:0] m_botoes;
  int         t;

  function automatic canal_t passo(canal_t c, logic [3:0] s, int tt);
    canal_t n = c;
    n.pulso = 1'b0;
    n.mult  = 1'b0;
    case (c.ph)
      0: if (s != 4'b0) begin n.cand = s; n.t0 = tt; n.ph = 1; end
      1: if (s != c.cand) n.ph = 0;
         else if (tt - c.t0 == D) n.ph = 2;
      2: begin
        if ($countones(c.cand) == 1) n.pulso = 1'b1;
        else n.mult = 1'b1;
        n.ph = 3;
      end
      3: if (s == 4'b0) begin n.ph = 4; n.t0 = tt; end
      4: if (s != 4'b0) n.ph = 3;
         else if (tt - c.t0 == D) n.ph = 0;
      default: n.ph = 0;
    endcase
    return n;
  endfunction

  task automatic modelo_reset();
    mb       = '{ph: 0, cand: 4'b0, t0: 0, pulso: 1'b0, mult: 1'b0};
    mj       = '{ph: 0, cand: 4'b0, t0: 0, pulso: 1'b0, mult: 1'b0};
    rb1      = 4'b0;
    rb2      = 4'b0;
    rj1      = 1'b0;
    rj2      = 1'b0;
    m_botoes = 4'b0;
  endtask

  task automatic modelo_passo();
    logic [3:0] sb;
    logic [3:0] sj;
    sb  = rb2;
    sj  = {3'b0, rj2};
    rb2 = rb1;
    rb1 = botoes_in;
    rj2 = rj1;
    rj1 = jogar_in;
    t   = t + 1;
    mb  = passo(mb, sb, t);
    mj  = passo(mj, sj, t);
    if (mb.pulso) m_botoes = mb.cand;
  endtask

  // One clock: model follows the rising edge, pulse counters sample at the falling edge.
  task automatic ciclo();
    @(posedge clock);
    if (!reset) modelo_reset();
    else        modelo_passo();
    @(negedge clock);
    cnt_tem  += int'(tem_jogada);
    cnt_jog  += int'(jogar);
    cnt_mult += int'(multiplo);
  endtask

  task automatic ciclos(input int n);
    repeat (n) ciclo();
  endtask

  task automatic zera_contagens();
    cnt_tem  = 0;
    cnt_jog  = 0;
    cnt_mult = 0;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    reset     = 1'b0;
    botoes_in = 4'b0010;
    jogar_in  = 1'b0;
    ciclos(3);
    obs = {botoes, tem_jogada, jogar, multiplo, db_estado};
    n_assert++;
    if (obs !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 11'b0);
    end
    reset = 1'b1;
    zera_contagens();
    ciclos(12);
    n_assert++;
    if (cnt_tem !== 1) begin
      n_fail++;
      $display("FAIL reset_held_pulses: got %0d expected 1", cnt_tem);
    end
    n_assert++;
    if (botoes !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_held_botoes: got %b expected 0010", botoes);
    end
    botoes_in = 4'b0;
    ciclos(12);
  endtask

  task automatic test_press_clean();
    int exp_est;
    zera_contagens();
    botoes_in = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      ciclo();
      n_assert++;
      if (tem_jogada !== (k == 8)) begin
        n_fail++;
        $display("FAIL press_latency k=%0d: got tem_jogada=%b expected %b", k, tem_jogada, (k == 8));
      end
      if (k == 2 || k == 3 || k == 7 || k == 8) begin
        exp_est = (k == 2) ? 0 : (k == 3) ? 1 : (k == 7) ? 2 : 3;
        n_assert++;
        if (db_estado !== 4'(exp_est)) begin
          n_fail++;
          $display("FAIL press_db_estado k=%0d: got %0d expected %0d", k, db_estado, exp_est);
        end
      end
    end
    n_assert++;
    if (cnt_tem !== 1 || botoes !== 4'b0100) begin
      n_fail++;
      $display("FAIL press_result: got pulses=%0d botoes=%b expected 1 and 0100", cnt_tem, botoes);
    end
    botoes_in = 4'b0;
    ciclos(12);
  endtask

  task automatic test_bounce();
    zera_contagens();
    for (int i = 0; i < 10; i++) begin
      botoes_in = (((i / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
      ciclo();
    end
    n_assert++;
    if (cnt_tem !== 0) begin
      n_fail++;
      $display("FAIL bounce_early: got %0d pulses expected 0", cnt_tem);
    end
    botoes_in = 4'b0001;
    ciclos(20);
    n_assert++;
    if (cnt_tem !== 1 || botoes !== 4'b0001) begin
      n_fail++;
      $display("FAIL bounce_result: got pulses=%0d botoes=%b expected 1 and 0001", cnt_tem, botoes);
    end
    botoes_in = 4'b0;
    ciclos(12);
  endtask

  task automatic test_multi();
    zera_contagens();
    botoes_in = 4'b0011;
    ciclos(10);
    n_assert++;
    if (cnt_mult !== 1 || cnt_tem !== 0) begin
      n_fail++;
      $display("FAIL multi_pulses: got multiplo=%0d tem=%0d expected 1 and 0", cnt_mult, cnt_tem);
    end
    n_assert++;
    if (botoes !== 4'b0001) begin
      n_fail++;
      $display("FAIL multi_botoes: got %b expected 0001", botoes);
    end
    botoes_in = 4'b0;
    ciclos(12);
  endtask

  task automatic test_release_glitch();
    int exp_est;
    zera_contagens();
    botoes_in = 4'b0100;
    ciclos(12);
    for (int k = 1; k <= 12; k++) begin
      botoes_in = (k == 4) ? 4'b1000 : 4'b0000;
      ciclo();
      if (k == 3 || k == 6 || k == 7) begin
        exp_est = (k == 6) ? 3 : 4;
        n_assert++;
        if (db_estado !== 4'(exp_est)) begin
          n_fail++;
          $display("FAIL glitch_db_estado k=%0d: got %0d expected %0d", k, db_estado, exp_est);
        end
      end
    end
    n_assert++;
    if (cnt_tem !== 1 || botoes !== 4'b0100) begin
      n_fail++;
      $display("FAIL glitch_no_pulse: got pulses=%0d botoes=%b expected 1 and 0100", cnt_tem, botoes);
    end
    zera_contagens();
    botoes_in = 4'b1000;
    ciclos(12);
    n_assert++;
    if (cnt_tem !== 1 || botoes !== 4'b1000) begin
      n_fail++;
      $display("FAIL glitch_clean_press: got pulses=%0d botoes=%b expected 1 and 1000", cnt_tem, botoes);
    end
    botoes_in = 4'b0;
    ciclos(12);
  endtask

  task automatic test_jogar_simult();
    int k_tem = -1;
    int k_jog = -1;
    zera_contagens();
    botoes_in = 4'b0010;
    jogar_in  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      ciclo();
      if (tem_jogada) k_tem = k;
      if (jogar)      k_jog = k;
    end
    n_assert++;
    if (cnt_jog !== 1 || cnt_tem !== 1) begin
      n_fail++;
      $display("FAIL simult_counts: got jogar=%0d tem=%0d expected 1 and 1", cnt_jog, cnt_tem);
    end
    n_assert++;
    if (k_jog !== 8 || k_tem !== 8) begin
      n_fail++;
      $display("FAIL simult_cycle: got jogar@%0d tem@%0d expected 8 and 8", k_jog, k_tem);
    end
    n_assert++;
    if (botoes !== 4'b0010) begin
      n_fail++;
      $display("FAIL simult_botoes: got %b expected 0010", botoes);
    end
    botoes_in = 4'b0;
    jogar_in  = 1'b0;
    ciclos(12);
  endtask

  task automatic test_random();
    logic [10:0] obs;
    logic [10:0] exp;
    int          dur;
    int          sel;
    int          cyc = 0;
    while (cyc < 800) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       botoes_in = 4'b0;
        1:       botoes_in = 4'b0001 << $urandom_range(0, 3);
        2:       botoes_in = 4'($urandom_range(0, 15));
        default: botoes_in = botoes_in;
      endcase
      if ($urandom_range(0, 2) == 0) jogar_in = ~jogar_in;
      dur = int'($urandom_range(1, 12));
      for (int i = 0; i < dur; i++) begin
        ciclo();
        cyc++;
        obs = {botoes, tem_jogada, multiplo, jogar, db_estado};
        exp = {m_botoes, mb.pulso, mb.mult, mj.pulso, 4'(mb.ph)};
        n_assert++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random_cycle %0d: got %b expected %b", cyc, obs, exp);
        end
      end
    end
    botoes_in = 4'b0;
    jogar_in  = 1'b0;
    ciclos(12);
  endtask

  initial begin
    t = 0;
    modelo_reset();
    test_reset();
    test_press_clean();
    test_bounce();
    test_multi();
    test_release_glitch();
    test_jogar_simult();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
